// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Brief    : Shared load/store request and response types for the data side.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam int unsigned c_LAT_W = 4;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic        write;
    mem_size_t   size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  // Encoding 2'b11 has no enumerator; it is the reserved size.
  function automatic logic is_reserved(input mem_size_t s);
    logic [1:0] v;
    v = s;
    return &v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Request/response bundle between the memory stage and the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i,
           req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i,
           req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_align
// Brief    : Byte-lane steering for stores, lane select/extension for loads,
//            and natural-alignment check.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_align
  import rv32i_pkg::*;
(
  input  mem_size_t   i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wlane,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] w_shifted;

  always_comb begin
    o_byte_en    = 4'b0000;
    o_wlane      = i_wdata;
    o_rdata      = 32'h0;
    o_misaligned = 1'b0;
    w_shifted    = i_rword >> {i_addr_lo, 3'b000};
    case (i_size)
      MEM_BYTE: begin
        o_byte_en = 4'b0001 << i_addr_lo;
        o_wlane   = {4{i_wdata[7:0]}};
        o_rdata   = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      end
      MEM_HALF: begin
        o_misaligned = i_addr_lo[0];
        o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wlane      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      end
      MEM_WORD: begin
        o_misaligned = |i_addr_lo;
        o_byte_en    = 4'b1111;
        o_rdata      = i_rword;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory responder with fixed latency.
//            Define RV32I_DMEM_STORE_RSP_EN to make successful stores respond.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int unsigned        c_AW     = $clog2(DEPTH);
  localparam logic [c_LAT_W-1:0] c_LAT_M1 = c_LAT_W'(LATENCY - 1);
`ifdef RV32I_DMEM_STORE_RSP_EN
  localparam logic               c_STORE_RSP = 1'b1;
`else
  localparam logic               c_STORE_RSP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t             r_state;
  logic [c_LAT_W-1:0] r_cnt;
  mem_req_t           r_req;
  logic               r_req_ready;
  logic               r_rsp_valid;
  mem_rsp_t           r_rsp;
  logic [31:0]        r_mem [DEPTH];

  mem_req_t    w_in;
  mem_req_t    w_cur;
  logic [c_AW-1:0] w_idx;
  logic        w_oor;
  logic        w_misaligned;
  logic        w_err;
  logic        w_accept;
  logic        w_silent;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;
  logic [31:0] w_rdata_ext;
  logic [31:0] w_rsp_data;

  always_comb begin
    w_in = '{write:       bus.req_write_i,
             size:        mem_size_t'(bus.req_size_i),
             is_unsigned: bus.req_unsigned_i,
             addr:        bus.req_addr_i,
             wdata:       bus.req_wdata_i};
  end

  // Live request while idle, captured copy afterwards; the same checks and
  // lane logic then serve both the acceptance edge and the WAIT->RESP edge.
  assign w_cur        = (r_state == S_IDLE) ? w_in : r_req;
  assign w_idx        = w_cur.addr[c_AW+1:2];
  assign w_oor        = (w_cur.addr[31:2] >= 30'(DEPTH));
  assign w_err        = w_misaligned | w_oor | is_reserved(w_cur.size);
  assign w_accept     = bus.req_valid_i & r_req_ready;
  assign w_silent     = w_in.write & ~w_err & ~c_STORE_RSP;
  assign w_we         = rst_i & w_accept & w_in.write & ~w_err;
  assign w_rsp_data   = (w_cur.write | w_err) ? 32'h0 : w_rdata_ext;

  dmem_align u_align (
    .i_size       (w_cur.size),
    .i_addr_lo    (w_cur.addr[1:0]),
    .i_unsigned   (w_cur.is_unsigned),
    .i_wdata      (w_cur.wdata),
    .i_rword      (r_mem[w_idx]),
    .o_byte_en    (w_be),
    .o_wlane      (w_wlane),
    .o_rdata      (w_rdata_ext),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_silent) begin
            r_req       <= w_in;
            r_req_ready <= 1'b0;
            r_cnt       <= c_LAT_M1;
            if (c_LAT_M1 == '0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp       <= '{rdata: w_rsp_data, err: w_err};
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_LAT_W'(1)) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp       <= '{rdata: w_rsp_data, err: w_err};
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp.rdata;
  assign bus.rsp_err_o   = r_rsp.err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Scoreboard bench for dmem_responder against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 3;
`ifdef RV32I_DMEM_STORE_RSP_EN
  localparam bit STORE_RSP = 1'b1;
`else
  localparam bit STORE_RSP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rsp_mode = 0;
  logic [7:0]  ref_mem [DEPTH*4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Byte-addressed reference: natural alignment, range and size rules only.
  function automatic void model_req(input logic wr, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic err, output logic rsp);
    int nb;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    err = 1'b0;
    if (nb == 0) err = 1'b1;
    else if ((addr % nb) != 0) err = 1'b1;
    if ((addr >> 2) >= DEPTH) err = 1'b1;
    rd  = 32'h0;
    rsp = 1'b1;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) ref_mem[addr + i] = wd[8*i +: 8];
        rsp = STORE_RSP;
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[addr + i];
        if (!uns && nb < 4 && v[8*nb-1]) begin
          for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        end
        rd = v;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, output int acc);
    logic [31:0] rd;
    logic        err;
    logic        rsp;
    int          guard;
    bus.req_write_i    = wr;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    bus.req_valid_i    = 1'b1;
    guard = 0;
    while (!bus.req_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept_timeout: req_ready %b, required 1", bus.req_ready_o);
      bus.req_valid_i = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    model_req(wr, sz, uns, addr, wd, rd, err, rsp);
    if (rsp) exp_q.push_back('{rdata: rd, err: err, acc: acc});
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid_o) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (!bus.rsp_valid_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.rsp_valid_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_valid_timeout: rsp_valid %b, required 1", bus.rsp_valid_o);
    end
  endtask

  initial begin
    bus.rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       bus.rsp_ready_i = 1'b1;
        1:       bus.rsp_ready_i = 1'($urandom_range(0, 1));
        default: bus.rsp_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: latency, hold-stability while stalled, and scoreboard pop.
  logic        prev_v = 1'b0;
  int          rise_cyc = 0;
  logic [31:0] held_d = 32'h0;
  logic        held_e = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid_o) begin
        if (!prev_v) begin
          rise_cyc = cyc;
          held_d   = bus.rsp_rdata_o;
          held_e   = bus.rsp_err_o;
        end else begin
          check("rsp_rdata_stable", bus.rsp_rdata_o, held_d);
          check("rsp_err_stable", {31'b0, bus.rsp_err_o}, {31'b0, held_e});
        end
        if (bus.rsp_ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rdata %h err %b, required no response",
                     bus.rsp_rdata_o, bus.rsp_err_o);
          end else begin
            mon_e = exp_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata_o, mon_e.rdata);
            check("rsp_err", {31'b0, bus.rsp_err_o}, {31'b0, mon_e.err});
            check("rsp_latency", 32'(rise_cyc - mon_e.acc), 32'(LATENCY));
          end
        end
      end
      prev_v = bus.rsp_valid_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;

    bus.req_valid_i    = 1'b0;
    bus.req_write_i    = 1'b0;
    bus.req_size_i     = 2'b00;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = 32'h0;
    bus.req_wdata_i    = 32'h0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", {31'b0, bus.req_ready_o}, 32'h1);
    check("reset_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata_o, 32'h0);
    check("reset_rsp_err", {31'b0, bus.rsp_err_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) send(1'b1, 2'd2, 1'b0, 32'(i*4), $urandom, a0);
    drain();

    send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, a0);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, a1);
    drain();

    send(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, a0);
    send(1'b1, 2'd0, 1'b0, 32'h13, 32'h12345680, a0);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, a0);
    send(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, a0);
    send(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, a0);
    drain();

    send(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, a0);
    send(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, a0);
    send(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, a0);
    send(1'b1, 2'd2, 1'b0, 32'h12, 32'hFFFFFFFF, a0);
    send(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFFFFFF, a0);
    send(1'b1, 2'd2, 1'b0, 32'h1000, 32'hFFFFFFFF, a0);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, a0);
    send(1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFEF00D, a0);
    send(1'b0, 2'd1, 1'b0, 32'hFFE, 32'h0, a0);
    drain();

    // Backpressure in RESP.
    rsp_mode = 2;
    @(negedge clk);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, a0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'h1);
      check("bp_req_ready", {31'b0, bus.req_ready_o}, 32'h0);
    end
    rsp_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("bp_release_ready", {31'b0, bus.req_ready_o}, 32'h1);
    drain();

    // Asynchronous reset in WAIT.
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, a0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_wait_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("rst_wait_ready", {31'b0, bus.req_ready_o}, 32'h1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, a0);
    drain();

    // Asynchronous reset in RESP.
    rsp_mode = 2;
    @(negedge clk);
    send(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, a0);
    wait_valid();
    #1 rst_n = 1'b0;
    #1;
    check("rst_resp_valid", {31'b0, bus.rsp_valid_o}, 32'h0);
    check("rst_resp_ready", {31'b0, bus.req_ready_o}, 32'h1);
    check("rst_resp_rdata", bus.rsp_rdata_o, 32'h0);
    exp_q.delete();
    rsp_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store immediately followed by a load of the same word.
    send(1'b1, 2'd2, 1'b0, 32'h20, $urandom, a0);
    send(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, a1);
    check("store_load_gap", 32'(a1 - a0), STORE_RSP ? 32'(LATENCY + 1) : 32'h1);
    drain();

    rsp_mode = 1;
    for (int n = 0; n < 300; n++) begin
      wr  = ($urandom_range(0, 99) < 40);
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255));
      else if ($urandom_range(0, 49) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, 63));
      send(wr, sz, uns, addr, $urandom, a0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rsp_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
